// File: rtl/spi_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_decoder
// Brief    : Parses SPI command bytes into framebuffer and control-register writes
// Revision : 1.0
// ============================================================================
module spi_cmd_decoder #(
  parameter int         ADDR_W     = 16,
  parameter logic [7:0] CTRL_RESET = 8'h00
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              DataRecv,
  input  logic [7:0]        DataIn,
  input  logic              CSel,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        MemData,
  output logic              MemWe,
  output logic [7:0]        CtrlReg,
  output logic              CtrlWe,
  output logic              ErrFlag,
  output logic              PktActive
);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_ADDR_HI = 3'd1;
  localparam logic [2:0] c_ST_ADDR_LO = 3'd2;
  localparam logic [2:0] c_ST_DATA    = 3'd3;
  localparam logic [2:0] c_ST_CTRL    = 3'd4;
  localparam logic [2:0] c_ST_DISCARD = 3'd5;

  localparam logic [7:0] c_OP_NOP     = 8'h00;
  localparam logic [7:0] c_OP_WRITE   = 8'h01;
  localparam logic [7:0] c_OP_SETCTRL = 8'h02;

  localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic              r_recv_s1, r_recv_s2, r_recv_s3;
  logic              r_csel_s1, r_csel_s2, r_csel_d;
  logic [2:0]        r_state;
  logic [7:0]        r_addr_hi;
  logic              w_byte_stb;
  logic              w_pkt_start;
  logic [ADDR_W-1:0] w_addr_load;

  assign w_byte_stb  = r_recv_s2 & ~r_recv_s3;
  assign w_pkt_start = r_csel_d & ~r_csel_s2;
  assign w_addr_load = ADDR_W'({r_addr_hi, DataIn});
  assign PktActive   = ~r_csel_s2;

  // Synchronizers; the CSel chain resets to idle so no packet appears active.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_recv_s1 <= 1'b0;
      r_recv_s2 <= 1'b0;
      r_recv_s3 <= 1'b0;
      r_csel_s1 <= 1'b1;
      r_csel_s2 <= 1'b1;
      r_csel_d  <= 1'b1;
    end else begin
      r_recv_s1 <= DataRecv;
      r_recv_s2 <= r_recv_s1;
      r_recv_s3 <= r_recv_s2;
      r_csel_s1 <= CSel;
      r_csel_s2 <= r_csel_s1;
      r_csel_d  <= r_csel_s2;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= c_ST_IDLE;
      r_addr_hi <= 8'h00;
      MemAddr   <= '0;
      MemData   <= 8'h00;
      MemWe     <= 1'b0;
      CtrlReg   <= CTRL_RESET;
      CtrlWe    <= 1'b0;
      ErrFlag   <= 1'b0;
    end else begin
      MemWe  <= 1'b0;
      CtrlWe <= 1'b0;
      if (MemWe) begin
        MemAddr <= MemAddr + c_ADDR_ONE;
      end
      if (w_pkt_start) begin
        ErrFlag <= 1'b0;
      end

      // Chip-select high overrides any byte arriving in the same cycle.
      if (r_csel_s2) begin
        r_state <= c_ST_IDLE;
      end else if (w_byte_stb) begin
        case (r_state)
          c_ST_IDLE: begin
            case (DataIn)
              c_OP_NOP:     r_state <= c_ST_IDLE;
              c_OP_WRITE:   r_state <= c_ST_ADDR_HI;
              c_OP_SETCTRL: r_state <= c_ST_CTRL;
              default: begin
                r_state <= c_ST_DISCARD;
                ErrFlag <= 1'b1;
              end
            endcase
          end
          c_ST_ADDR_HI: begin
            r_addr_hi <= DataIn;
            r_state   <= c_ST_ADDR_LO;
          end
          c_ST_ADDR_LO: begin
            MemAddr <= w_addr_load;
            r_state <= c_ST_DATA;
          end
          c_ST_DATA: begin
            MemData <= DataIn;
            MemWe   <= 1'b1;
          end
          c_ST_CTRL: begin
            CtrlReg <= DataIn;
            CtrlWe  <= 1'b1;
            r_state <= c_ST_DISCARD;
          end
          default: r_state <= c_ST_DISCARD;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for spi_cmd_decoder: Clk = 4x Sclk, random SPI phase, packet-level reference model.
module tb_spi_cmd_decoder;

  localparam int         ADDR_W     = 16;
  localparam logic [7:0] CTRL_RESET = 8'h00;
  localparam int         SCLK_P     = 40;

  logic              Clk      = 1'b0;
  logic              Reset    = 1'b1;
  logic              DataRecv = 1'b0;
  logic [7:0]        DataIn   = 8'h00;
  logic              CSel     = 1'b1;
  logic [ADDR_W-1:0] MemAddr;
  logic [7:0]        MemData;
  logic              MemWe;
  logic [7:0]        CtrlReg;
  logic              CtrlWe;
  logic              ErrFlag;
  logic              PktActive;

  spi_cmd_decoder #(.ADDR_W(ADDR_W), .CTRL_RESET(CTRL_RESET)) dut (
    .Clk(Clk), .Reset(Reset), .DataRecv(DataRecv), .DataIn(DataIn), .CSel(CSel),
    .MemAddr(MemAddr), .MemData(MemData), .MemWe(MemWe),
    .CtrlReg(CtrlReg), .CtrlWe(CtrlWe), .ErrFlag(ErrFlag), .PktActive(PktActive)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [15:0] a; logic [7:0] d; int lat; } wr_t;

  wr_t         got_q[$];
  wr_t         exp_q[$];
  logic [7:0]  gotc_q[$];
  int          gotc_lat_q[$];
  logic [7:0]  expc_q[$];
  logic [7:0]  pkt[$];
  logic [15:0] m_addr;
  logic [7:0]  m_data, m_ctrl;
  logic        m_err;
  int          n_cmp = 0, n_bad = 0;
  int          edge_cnt = 0, rise_edge = 0, phase = 3;
  bit          both_hi = 1'b0;

  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  // Latency is counted in Clk rising edges since DataRecv last rose.
  always @(negedge Clk) begin
    if (MemWe) got_q.push_back('{a: MemAddr, d: MemData, lat: edge_cnt - rise_edge});
    if (CtrlWe) begin
      gotc_q.push_back(CtrlReg);
      gotc_lat_q.push_back(edge_cnt - rise_edge);
    end
    if (MemWe && CtrlWe) both_hi = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_phase();
    int p;
    p = $urandom_range(1, 8);
    if (p >= 5) p++;
    return p;
  endfunction

  task automatic align();
    int d;
    d = (phase + 10 - int'($time % 64'd10)) % 10;
    #(d);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit drop);
    align();
    DataIn    = b;
    DataRecv  = 1'b1;
    rise_edge = edge_cnt;
    if (drop) CSel = 1'b1;
    #(SCLK_P);
    DataRecv = 1'b0;
    #(7 * SCLK_P);
  endtask

  // Reference: interpret the delivered bytes of one packet as commands.
  task automatic model(input int n);
    int i;
    logic [7:0]  op;
    logic [15:0] a;
    exp_q.delete();
    expc_q.delete();
    m_err = 1'b0;
    i = 0;
    while (i < n) begin
      op = pkt[i];
      i++;
      if (op == 8'h00) continue;
      if (op == 8'h01) begin
        if (i + 2 > n) break;
        a = {pkt[i], pkt[i+1]};
        i += 2;
        while (i < n) begin
          exp_q.push_back('{a: a, d: pkt[i], lat: 0});
          m_data = pkt[i];
          a = a + 16'd1;
          i++;
        end
        m_addr = a;
      end else if (op == 8'h02) begin
        if (i < n) begin
          expc_q.push_back(pkt[i]);
          m_ctrl = pkt[i];
        end
      end else begin
        m_err = 1'b1;
      end
      break;
    end
  endtask

  task automatic check_results();
    @(negedge Clk);
    chk("mem_we_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk("mem_addr", got_q[i].a, exp_q[i].a);
      chk("mem_data", got_q[i].d, exp_q[i].d);
      chk("mem_we_latency_ok", (got_q[i].lat == 3 || got_q[i].lat == 4), 1);
    end
    chk("ctrl_we_count", gotc_q.size(), expc_q.size());
    for (int i = 0; i < expc_q.size() && i < gotc_q.size(); i++) begin
      chk("ctrl_value", gotc_q[i], expc_q[i]);
      chk("ctrl_we_latency_ok", (gotc_lat_q[i] == 3 || gotc_lat_q[i] == 4), 1);
    end
    chk("mem_addr_final", MemAddr, m_addr);
    chk("mem_data_final", MemData, m_data);
    chk("ctrl_reg_final", CtrlReg, m_ctrl);
    chk("err_flag", ErrFlag, m_err);
    chk("pkt_active_idle", PktActive, 0);
    chk("we_overlap", both_hi, 0);
  endtask

  task automatic do_packet(input bit drop_last);
    int n;
    phase = pick_phase();
    n = pkt.size() - (drop_last ? 1 : 0);
    model(n);
    got_q.delete();
    gotc_q.delete();
    gotc_lat_q.delete();
    align();
    CSel = 1'b0;
    #80;
    chk("pkt_active_busy", PktActive, 1);
    foreach (pkt[i]) send_byte(pkt[i], drop_last && (i == pkt.size() - 1));
    #100;
    CSel = 1'b1;
    #100;
    check_results();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mem_addr", MemAddr, 0);
    chk("rst_mem_data", MemData, 0);
    chk("rst_mem_we", MemWe, 0);
    chk("rst_ctrl_reg", CtrlReg, CTRL_RESET);
    chk("rst_ctrl_we", CtrlWe, 0);
    chk("rst_err_flag", ErrFlag, 0);
    chk("rst_pkt_active", PktActive, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk_reset_outputs();
    Reset  = 1'b0;
    m_addr = 16'h0000;
    m_data = 8'h00;
    m_ctrl = CTRL_RESET;
    m_err  = 1'b0;
    #20;

    pkt = {8'h01, 8'h12, 8'h34, 8'hAA, 8'hBB, 8'hCC}; do_packet(1'b0);
    pkt = {8'h01, 8'hFF, 8'hFF, 8'h11, 8'h22};        do_packet(1'b0);
    pkt = {8'h02, 8'h5A, 8'h77};                      do_packet(1'b0);
    pkt = {8'h7E, 8'h01, 8'h00, 8'h00, 8'h33};        do_packet(1'b0);
    pkt = {8'h00};                                    do_packet(1'b0);
    pkt = {8'h01, 8'h00};                             do_packet(1'b0);
    pkt = {8'h01, 8'h00, 8'h10, 8'h44};               do_packet(1'b0);
    // Last byte collides with CSel rising and must be dropped.
    pkt = {8'h01, 8'h00, 8'h20, 8'h99};               do_packet(1'b1);

    // Reset in the middle of a WRITE command.
    phase = pick_phase();
    align();
    CSel = 1'b0;
    #80;
    send_byte(8'h01, 1'b0);
    send_byte(8'hAB, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk_reset_outputs();
    CSel = 1'b1;
    @(negedge Clk);
    Reset  = 1'b0;
    m_addr = 16'h0000;
    m_data = 8'h00;
    m_ctrl = CTRL_RESET;
    m_err  = 1'b0;
    pkt = {8'h01, 8'h00, 8'h02, 8'h55};               do_packet(1'b0);

    for (int k = 0; k < 10; k++) begin
      kind = $urandom_range(0, 3);
      pkt.delete();
      case (kind)
        0: begin
          pkt.push_back(8'h01);
          pkt.push_back(($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom));
          pkt.push_back(8'($urandom));
          repeat ($urandom_range(1, 4)) pkt.push_back(8'($urandom));
        end
        1: begin
          pkt.push_back(8'h02);
          repeat ($urandom_range(0, 2)) pkt.push_back(8'($urandom));
        end
        2: begin
          pkt.push_back(8'h00);
          pkt.push_back(8'h01);
          repeat (3) pkt.push_back(8'($urandom));
        end
        default: begin
          pkt.push_back(8'($urandom_range(3, 255)));
          repeat ($urandom_range(0, 3)) pkt.push_back(8'($urandom));
        end
      endcase
      do_packet($urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- Consumes bytes from the Sclk-domain SPI byte receiver: DataRecv strobe plus the 8-bit DataOut byte.
- Brings the strobe and chip-select into the system Clk domain.
- Parses command packets and issues framebuffer write strobes with auto-incrementing address, plus a control-register write.
- Sits between the SPI receiver and the VGA framebuffer/control logic.

Parameters:
ADDR_W, 16, framebuffer address width; the address is built from two SPI bytes (hi, lo) and truncated to ADDR_W bits.
CTRL_RESET, 8'h00, reset value of CtrlReg.

Ports:
Clk  in  1  system clock; all logic is on its rising edge.
Reset  in  1  synchronous, active-high reset.
DataRecv  in  1  byte-valid strobe from the SPI receiver; asynchronous to Clk, high for one Sclk period.
DataIn  in  8  received byte; asynchronous; stable for ≥7 Sclk periods after DataRecv rises.
CSel  in  1  SPI chip select; asynchronous; high = bus idle / packet boundary.
MemAddr  out  ADDR_W  framebuffer write address.
MemData  out  8  framebuffer write data.
MemWe  out  1  one-Clk write pulse; MemAddr/MemData are valid while it is high.
CtrlReg  out  8  control register.
CtrlWe  out  1  one-Clk pulse when CtrlReg is updated.
ErrFlag  out  1  sticky flag: unknown opcode seen in the current packet.
PktActive  out  1  high while the synchronized CSel is low.

Behaviour:
- Clock ratio: Clk ≥ 4× Sclk is required. Slower Clk may miss DataRecv pulses; this is out of scope.
- Synchronizers:
  - DataRecv: 3-flop chain s1→s2→s3; ByteStb = s2 & ~s3.
  - CSel: 2-flop synchronizer → CSelS.
  - DataIn is sampled only in the ByteStb cycle. Bits are stable by then because of the ratio rule.
- Latency: MemWe/CtrlWe assert on the 3rd Clk rising edge after DataRecv rises (+1 cycle synchronizer uncertainty). Each write pulse lasts exactly 1 cycle.
- Abort:
  - While CSelS=1: FSM is forced to IDLE and ByteStb is ignored.
  - If CSelS=1 in the same cycle as ByteStb, the abort wins and the byte is discarded.
  - No write is issued for a partial packet.
- ErrFlag clears on the CSelS 1→0 transition (start of a new packet) and on Reset.
- PktActive = ~CSelS.
- FSM states: IDLE, ADDR_HI, ADDR_LO, DATA, CTRL, DISCARD. Each transition below happens on ByteStb with CSelS=0, using byte B:
  - IDLE:
    - B=8'h00 (NOP) → IDLE.
    - B=8'h01 (WRITE) → ADDR_HI.
    - B=8'h02 (SETCTRL) → CTRL.
    - Any other B → DISCARD, ErrFlag←1.
  - ADDR_HI: address hi byte ← B → ADDR_LO.
  - ADDR_LO: MemAddr ← {hi, B}[ADDR_W-1:0] → DATA. No write.
  - DATA:
    - MemData ← B, MemWe pulse at the current MemAddr.
    - MemAddr increments in the cycle after the pulse.
    - Wraps all-ones → 0 with no flag.
    - Stays in DATA for an unlimited stream until abort.
  - CTRL: CtrlReg ← B, CtrlWe pulse → DISCARD. Further bytes are ignored.
  - DISCARD: bytes ignored until abort.
- Reset (any time, including mid-packet):
  - FSM=IDLE.
  - MemAddr=0, MemData=0, MemWe=0.
  - CtrlReg=CTRL_RESET, CtrlWe=0.
  - ErrFlag=0.
  - Synchronizer flops=0, except CSel synchronizer=1 (idle), so PktActive=0.
- MemAddr and MemData hold their last values between writes. MemWe and CtrlWe are never high in the same cycle.

Test Plan:
- Reset, then CSel low, bytes 01,12,34,AA,BB,CC, CSel high → MemWe pulses at MemAddr 0x1234/0x1235/0x1236 with MemData AA/BB/CC. Exactly 3 pulses. MemAddr=0x1237 afterward.
- Wrap: bytes 01,FF,FF,11,22 → writes at 0xFFFF (11) then 0x0000 (22).
- Bytes 02,5A,77 → CtrlReg=5A with a single CtrlWe pulse. The 77 has no effect. No MemWe.
- Bytes 7E,01,00,00,33 → ErrFlag=1, no writes. Next packet (CSel high→low) with byte 00 → ErrFlag=0.
- Abort: 01,00 then CSel high, then a new packet 01,00,10,44 → single write 44 at 0x0010. No write from the aborted packet. Also drive CSel rising in the same Clk as ByteStb → byte dropped.
- Reset asserted after 01,AB → all outputs return to reset values. A following 01,00,02,55 writes 55 at 0x0002. Run at Clk = 4× Sclk, minimum ratio, with random phase → no dropped bytes.
